// File: rtl/divider_64bits_pkg.sv
// Shared definitions for the sequential restoring divider: operand width
// default and the FSM state encoding (also used by the bench for state coverage).
package divider_64bits_pkg;

  localparam int DIV_BITS = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/divider_64bits_if.sv
// Load/result handshake bundle of the divider. The master side loads operands
// with w_en; the slave side (the divider) returns busy/ok_flag and the results.
interface divider_64bits_if #(parameter int BITS = 64);

  logic            w_en;
  logic [BITS-1:0] a_in;
  logic [BITS-1:0] b_in;
  logic            busy;
  logic            ok_flag;
  logic            div_zero;
  logic [BITS-1:0] quotient_out;
  logic [BITS-1:0] remainder_out;

  modport master (
    output w_en, a_in, b_in,
    input  busy, ok_flag, div_zero, quotient_out, remainder_out
  );

  modport slave (
    input  w_en, a_in, b_in,
    output busy, ok_flag, div_zero, quotient_out, remainder_out
  );

endinterface

// File: rtl/divider_64bits_sub.sv
// Generic N-bit unsigned subtractor. borrow_out=1 means A_in < B_in, i.e. the
// restoring step fails and the trial value must be kept.
module subtractor_nbits #(
  parameter int N = 65
) (
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  output logic [N-1:0] diff_out,
  output logic         borrow_out
);

  logic [N:0] wide_s;

  assign wide_s     = {1'b0, A_in} - {1'b0, B_in};
  assign diff_out   = wide_s[N-1:0];
  assign borrow_out = wide_s[N];

endmodule

// File: rtl/divider_64bits.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// The dividend is shifted out of the quotient register while quotient bits are
// shifted in; divide by zero completes in one extra cycle with q = all ones.
module divider_64bits
  import divider_64bits_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input  logic           clk,
  input  logic           reset,
  divider_64bits_if.slave bus
);

  localparam int            CW   = $clog2(BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] divisor_q, divisor_d;
  logic [BITS-1:0] quot_q, quot_d;
  logic [BITS:0]   rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            ok_q, ok_d;
  logic            dz_q, dz_d;

  logic [BITS:0]   trial_s;
  logic [BITS:0]   diff_s;
  logic            borrow_s;
  // After every step the partial remainder is below the divisor, so its top
  // bit is always zero and never feeds the next trial value.
  logic            rem_top_unused_s;

  assign trial_s          = {rem_q[BITS-1:0], quot_q[BITS-1]};
  assign rem_top_unused_s = rem_q[BITS];

  subtractor_nbits #(.N(BITS + 1)) u_sub (
    .A_in       (trial_s),
    .B_in       ({1'b0, divisor_q}),
    .diff_out   (diff_s),
    .borrow_out (borrow_s)
  );

  // Next-state logic: a load has priority in every state, otherwise iterate or hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    ok_d      = ok_q;
    dz_d      = dz_q;
    if (bus.w_en) begin
      divisor_d = bus.b_in;
      cnt_d     = '0;
      ok_d      = 1'b0;
      if (bus.b_in == '0) begin
        // Result is final now; ok_flag follows one cycle later from DONE.
        state_d = S_DONE;
        quot_d  = '1;
        rem_d   = {1'b0, bus.a_in};
        busy_d  = 1'b0;
        dz_d    = 1'b1;
      end else begin
        state_d = S_RUN;
        quot_d  = bus.a_in;
        rem_d   = '0;
        busy_d  = 1'b1;
        dz_d    = 1'b0;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          quot_d = {quot_q[BITS-2:0], ~borrow_s};
          rem_d  = borrow_s ? trial_s : diff_s;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            ok_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          ok_d = 1'b1;
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ok_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      ok_q      <= ok_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.ok_flag       = ok_q;
  assign bus.div_zero      = dz_q;
  assign bus.quotient_out  = quot_q;
  assign bus.remainder_out = rem_q[BITS-1:0];

endmodule

// File: tb/tb_divider_64bits.sv
// Self-checking bench for divider_64bits: directed vector table, abort and
// asynchronous-reset sequences, and random operands checked against / and %.
module tb_divider_64bits;
  import divider_64bits_pkg::*;

  localparam int BITS = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  divider_64bits_if #(.BITS(BITS)) bus ();

  divider_64bits #(.BITS(BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  logic [2:0] seen = 3'b000;

  // Record which FSM states the design visits.
  always @(negedge clk) begin
    case (dut.state_q)
      S_IDLE:  seen[0] <= 1'b1;
      S_RUN:   seen[1] <= 1'b1;
      S_DONE:  seen[2] <= 1'b1;
      default: seen    <= seen;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load one division, wait (bounded) for ok_flag and check results and latency.
  task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er,
                         input logic edz, input int elat);
    int cyc;
    logic [63:0] q_snap;
    @(negedge clk);
    bus.w_en = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.a_in = ~a;
    bus.b_in = ~b;
    check({tag, " ok_clr"}, {63'd0, bus.ok_flag}, 64'd0);
    check({tag, " busy_on"}, {63'd0, bus.busy}, {63'd0, (b != 64'd0)});
    cyc = 0;
    while (!bus.ok_flag && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check({tag, " latency"}, 64'(cyc), 64'(elat));
    check({tag, " quot"}, bus.quotient_out, eq);
    check({tag, " rem"}, bus.remainder_out, er);
    check({tag, " dz"}, {63'd0, bus.div_zero}, {63'd0, edz});
    check({tag, " busy_off"}, {63'd0, bus.busy}, 64'd0);
    q_snap = bus.quotient_out;
    @(posedge clk);
    #1;
    check({tag, " hold"}, {63'd0, bus.ok_flag} ^ (bus.quotient_out ^ q_snap), 64'd1);
  endtask

  initial begin
    int any_ok;
    logic [63:0] ra, rb;

    vecs[0]  = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 64};
    vecs[1]  = '{64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 64};
    vecs[2]  = '{ONES, 64'd1, ONES, 64'd0, 1'b0, 64};
    vecs[3]  = '{64'd1234, 64'd0, ONES, 64'd1234, 1'b1, 1};
    vecs[4]  = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 64};
    vecs[5]  = '{ONES, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64};
    vecs[6]  = '{ONES, ONES, 64'd1, 64'd0, 1'b0, 64};
    vecs[7]  = '{64'd1000000, 64'd1000, 64'd1000, 64'd0, 1'b0, 64};
    vecs[8]  = '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 64};
    vecs[9]  = '{ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0, 64};
    vecs[10] = '{64'd6, 64'd7, 64'd0, 64'd6, 1'b0, 64};
    vecs[11] = '{64'd0, 64'd0, ONES, 64'd0, 1'b1, 1};

    bus.w_en = 1'b0;
    bus.a_in = 64'd0;
    bus.b_in = 64'd0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {63'd0, bus.busy}, 64'd0);
    check("rst ok", {63'd0, bus.ok_flag}, 64'd0);
    check("rst dz", {63'd0, bus.div_zero}, 64'd0);
    check("rst quot", bus.quotient_out, 64'd0);
    check("rst rem", bus.remainder_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle ok", {63'd0, bus.ok_flag}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              vecs[i].dz, vecs[i].lat);
    end

    // Abort: reload during a run; the old operation must never flag ok.
    @(negedge clk);
    bus.w_en = 1'b1;
    bus.a_in = 64'd100;
    bus.b_in = 64'd7;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    any_ok = 0;
    repeat (19) begin
      @(posedge clk);
      #1;
      if (bus.ok_flag) any_ok = 1;
    end
    check("abort no_ok", 64'(any_ok), 64'd0);
    run_div("abort", 64'd81, 64'd9, 64'd9, 64'd0, 1'b0, 64);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.w_en = 1'b1;
    bus.a_in = 64'd100;
    bus.b_in = 64'd7;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst busy", {63'd0, bus.busy}, 64'd0);
    check("arst ok", {63'd0, bus.ok_flag}, 64'd0);
    check("arst quot", bus.quotient_out, 64'd0);
    check("arst rem", bus.remainder_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    any_ok = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.ok_flag || bus.busy) any_ok = 1;
    end
    check("arst idle", 64'(any_ok), 64'd0);
    run_div("post_rst", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 64);

    // Random operands against the language's own division.
    for (int i = 0; i < 150; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = {$urandom, $urandom};
        1:       rb = 64'($urandom_range(1, 1000));
        2:       rb = 64'h8000_0000_0000_0000;
        default: rb = ra + 64'd1 + 64'($urandom_range(0, 50));
      endcase
      if (rb == 64'd0) rb = 64'd1;
      run_div($sformatf("rnd%0d", i), ra, rb, ra / rb, ra % rb, 1'b0, 64);
    end

    @(negedge clk);
    check("states", {61'd0, seen}, 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
